// File: rtl/rggen_bus_pkg.sv
// Shared rggen register-bus encodings: access codes, response status codes and bridge FSM states.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package rggen_bus_pkg;

  // Register-bus access codes; the MSB marks a valid access and the LSB marks a write.
  typedef enum logic [1:0] {
    RGGEN_READ  = 2'b10,
    RGGEN_WRITE = 2'b11
  } rggen_access_e;

  // Register-bus response status codes.
  typedef enum logic [1:0] {
    RGGEN_OKAY        = 2'b00,
    RGGEN_EXOKAY      = 2'b01,
    RGGEN_SLAVE_ERROR = 2'b10,
    RGGEN_ERROR       = 2'b11
  } rggen_status_e;

  // APB bridge FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } rggen_bridge_state_e;

  // A response is an error when it is a slave error or a decode error.
  function automatic logic rggen_is_error(input logic [1:0] status);
    return (status == RGGEN_SLAVE_ERROR) || (status == RGGEN_ERROR);
  endfunction

endpackage

// File: rtl/rggen_apb_bridge.sv
// APB4 slave front-end converting one APB transfer into one rggen register-bus access.
// Latency: setup at T -> register valid at T+1; register ready at R -> PREADY at R+1 (3-cycle minimum).
// Backpressure: PREADY stays low while an access is outstanding; optional timeout via RGGEN_APB_BRIDGE_TIMEOUT_EN.
module rggen_apb_bridge
  import rggen_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic                     i_pwrite,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_pslverr,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;
  localparam int ADDR_LSB   = $clog2(STRB_WIDTH);
  // Clears the byte-offset bits so the register bus always sees word-aligned addresses.
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = {ADDRESS_WIDTH{1'b1}} << ADDR_LSB;

  // Elaboration-time guards on the parameter ranges this bridge supports.
  if (!((BUS_WIDTH == 8) || (BUS_WIDTH == 16) || (BUS_WIDTH == 32) || (BUS_WIDTH == 64))) begin : g_bad_bus_width
    $error("rggen_apb_bridge: BUS_WIDTH must be 8, 16, 32 or 64");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("rggen_apb_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  rggen_bridge_state_e        state_q, state_d;
  logic [1:0]                 access_q, access_d;
  logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
  logic [BUS_WIDTH-1:0]       write_data_q, write_data_d;
  logic [STRB_WIDTH-1:0]      strobe_q, strobe_d;
  logic [BUS_WIDTH-1:0]       prdata_q, prdata_d;
  logic                       pslverr_q, pslverr_d;
  // Set when PSEL drops during BUSY; the access finishes but its response is discarded.
  logic                       abort_q, abort_d;
  logic                       timeout_hit;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int COUNT_WIDTH_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int COUNT_WIDTH     = (COUNT_WIDTH_RAW < 8)  ? 8 :
                                   (COUNT_WIDTH_RAW > 16) ? 16 : COUNT_WIDTH_RAW;
  // The count of the final BUSY cycle; valid is therefore high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  assign timeout_hit = (state_q == BUSY) && (count_q == COUNT_LAST);

  // Timeout counter: held at zero outside BUSY so every access starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (state_q != BUSY) begin
      count_d = '0;
    end else if (!timeout_hit) begin
      count_d = count_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and request/response capture logic.
  always_comb begin
    state_d      = state_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    prdata_d     = prdata_q;
    pslverr_d    = pslverr_q;
    abort_d      = abort_q;

    case (state_q)
      IDLE: begin
        // Only a setup phase starts an access; request fields freeze until the next IDLE.
        if (i_psel && !i_penable) begin
          state_d      = BUSY;
          access_d     = i_pwrite ? RGGEN_WRITE : RGGEN_READ;
          address_d    = i_paddr & ADDR_MASK;
          write_data_d = i_pwrite ? i_pwdata : '0;
          strobe_d     = i_pwrite ? i_pstrb : '1;
          abort_d      = 1'b0;
        end
      end
      BUSY: begin
        if (!i_psel) begin
          abort_d = 1'b1;
        end
        if (i_register_ready) begin
          pslverr_d = rggen_is_error(i_register_status);
          prdata_d  = ((access_q == RGGEN_READ) && !rggen_is_error(i_register_status))
                      ? i_register_read_data : '0;
          state_d   = abort_d ? IDLE : RESP;
        end else if (timeout_hit) begin
          pslverr_d = 1'b1;
          prdata_d  = '0;
          state_d   = abort_d ? IDLE : RESP;
        end
      end
      RESP: begin
        state_d   = IDLE;
        prdata_d  = '0;
        pslverr_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-field registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      prdata_q     <= '0;
      pslverr_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      prdata_q     <= prdata_d;
      pslverr_q    <= pslverr_d;
      abort_q      <= abort_d;
    end
  end

  assign o_register_valid      = (state_q == BUSY);
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

  // Response fields are forced to zero outside the single PREADY cycle.
  assign o_pready  = (state_q == RESP);
  assign o_prdata  = o_pready ? prdata_q : '0;
  assign o_pslverr = o_pready & pslverr_q;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Directed self-checking bench for rggen_apb_bridge (32-bit bus, 8-bit address, TIMEOUT_CYCLES=4).
// Latency: checks setup->valid, ready->PREADY and total APB cycle counts per transfer.
// Backpressure: exercises long waits, back-to-back, PSEL drop, reset mid-access and the optional timeout.
`timescale 1ns/1ps
module tb_rggen_apb_bridge;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int SW = BW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_psel, i_penable, i_pwrite;
  logic [AW-1:0] i_paddr;
  logic [BW-1:0] i_pwdata;
  logic [SW-1:0] i_pstrb;
  logic          o_pready, o_pslverr;
  logic [BW-1:0] o_prdata;
  logic          o_register_valid;
  logic [1:0]    o_register_access;
  logic [AW-1:0] o_register_address;
  logic [BW-1:0] o_register_write_data;
  logic [SW-1:0] o_register_strobe;
  logic          i_register_ready;
  logic [1:0]    i_register_status;
  logic [BW-1:0] i_register_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Observations recorded by the APB driver for the most recent transfer.
  logic [1:0]    obs_access;
  logic [AW-1:0] obs_addr;
  logic [BW-1:0] obs_wdata;
  logic [SW-1:0] obs_strb;
  logic [BW-1:0] obs_prdata;
  logic          obs_pslverr;
  logic          obs_stable;
  logic          obs_valid_at_setup;
  logic          obs_pready_after;
  logic          obs_done;
  int            obs_valid_cycles;
  int            obs_cycles;

  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk                 (clk),
    .i_rst                 (i_rst),
    .i_psel                (i_psel),
    .i_penable             (i_penable),
    .i_paddr               (i_paddr),
    .i_pwrite              (i_pwrite),
    .i_pwdata              (i_pwdata),
    .i_pstrb               (i_pstrb),
    .o_pready              (o_pready),
    .o_prdata              (o_prdata),
    .o_pslverr             (o_pslverr),
    .o_register_valid      (o_register_valid),
    .o_register_access     (o_register_access),
    .o_register_address    (o_register_address),
    .o_register_write_data (o_register_write_data),
    .o_register_strobe     (o_register_strobe),
    .i_register_ready      (i_register_ready),
    .i_register_status     (i_register_status),
    .i_register_read_data  (i_register_read_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_psel = 0; i_penable = 0; i_pwrite = 0; i_paddr = '0; i_pwdata = '0; i_pstrb = '0;
    i_register_ready = 0; i_register_status = '0; i_register_read_data = '0;
  endtask

  // One APB transfer starting in the current cycle; the register side answers dly cycles after valid rises.
  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wdata,
                          input logic [SW-1:0] strb, input int dly, input logic [BW-1:0] rdata,
                          input logic [1:0] status);
    int k;
    int n;
    k = 0; n = 0;
    obs_valid_at_setup = o_register_valid;
    obs_valid_cycles = 0; obs_stable = 1; obs_done = 0; obs_prdata = '0; obs_pslverr = 0;
    i_psel = 1; i_penable = 0; i_pwrite = wr; i_paddr = addr; i_pwdata = wdata; i_pstrb = strb;
    obs_cycles = 1;
    step();
    // Access phase; the request inputs are scrambled so only registered copies can look right.
    i_penable = 1; i_paddr = ~addr; i_pwdata = ~wdata; i_pstrb = ~strb;
    obs_cycles = 2;
    while (!obs_done && n < 60) begin
      i_register_ready = 0; i_register_status = '0; i_register_read_data = '0;
      if (o_pready) begin
        obs_done = 1; obs_prdata = o_prdata; obs_pslverr = o_pslverr;
      end else begin
        if (o_register_valid) begin
          if (k == 0) begin
            obs_access = o_register_access; obs_addr = o_register_address;
            obs_wdata = o_register_write_data; obs_strb = o_register_strobe;
          end else if ({o_register_access, o_register_address, o_register_write_data, o_register_strobe}
                       !== {obs_access, obs_addr, obs_wdata, obs_strb}) begin
            obs_stable = 0;
          end
          if (k == dly) begin
            i_register_ready = 1; i_register_status = status; i_register_read_data = rdata;
          end
          k++;
          obs_valid_cycles++;
        end
        step();
        obs_cycles++;
        n++;
      end
    end
    n_checks++;
    if (!obs_done) begin
      n_fail++;
      $display("FAIL xfer_done: o_pready=%b after 60 cycles, required 1", o_pready);
    end
    step();
    obs_pready_after = o_pready;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1;
    repeat (3) step();
    n_checks++; if (o_pready !== 1'b0) begin n_fail++; $display("FAIL rst_pready: got %b, want 0", o_pready); end
    n_checks++; if (o_prdata !== '0) begin n_fail++; $display("FAIL rst_prdata: got %h, want 0", o_prdata); end
    n_checks++; if (o_pslverr !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr: got %b, want 0", o_pslverr); end
    n_checks++; if (o_register_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, want 0", o_register_valid); end
    n_checks++; if (o_register_access !== 2'b00) begin n_fail++; $display("FAIL rst_access: got %b, want 00", o_register_access); end
    n_checks++; if (o_register_address !== 8'h00) begin n_fail++; $display("FAIL rst_address: got %h, want 00", o_register_address); end
    n_checks++; if (o_register_write_data !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h, want 0", o_register_write_data); end
    n_checks++; if (o_register_strobe !== 4'h0) begin n_fail++; $display("FAIL rst_strobe: got %h, want 0", o_register_strobe); end
    i_rst = 0;
    step();
  endtask

  task automatic test_write();
    apb_xfer(1'b1, 8'h10, 32'h0000_00AA, 4'b0001, 2, 32'h1234_5678, 2'b00);
    n_checks++; if (obs_access !== 2'b11) begin n_fail++; $display("FAIL wr_access: got %b, want 11", obs_access); end
    n_checks++; if (obs_addr !== 8'h10) begin n_fail++; $display("FAIL wr_address: got %h, want 10", obs_addr); end
    n_checks++; if (obs_strb !== 4'b0001) begin n_fail++; $display("FAIL wr_strobe: got %b, want 0001", obs_strb); end
    n_checks++; if (obs_wdata !== 32'h0000_00AA) begin n_fail++; $display("FAIL wr_wdata: got %h, want 000000aa", obs_wdata); end
    n_checks++; if (obs_stable !== 1'b1) begin n_fail++; $display("FAIL wr_stable: got %b, want 1", obs_stable); end
    n_checks++; if (obs_valid_cycles !== 3) begin n_fail++; $display("FAIL wr_valid_cycles: got %0d, want 3", obs_valid_cycles); end
    n_checks++; if (obs_cycles !== 5) begin n_fail++; $display("FAIL wr_cycles: got %0d, want 5", obs_cycles); end
    n_checks++; if (obs_pslverr !== 1'b0) begin n_fail++; $display("FAIL wr_pslverr: got %b, want 0", obs_pslverr); end
    n_checks++; if (obs_prdata !== 32'h0) begin n_fail++; $display("FAIL wr_prdata: got %h, want 0", obs_prdata); end
    n_checks++; if (obs_pready_after !== 1'b0) begin n_fail++; $display("FAIL wr_pready_pulse: got %b after pulse, want 0", obs_pready_after); end
  endtask

  task automatic test_read();
    apb_xfer(1'b0, 8'h13, 32'hFFFF_FFFF, 4'h0, 0, 32'hDEAD_BEEF, 2'b00);
    n_checks++; if (obs_access !== 2'b10) begin n_fail++; $display("FAIL rd_access: got %b, want 10", obs_access); end
    n_checks++; if (obs_addr !== 8'h10) begin n_fail++; $display("FAIL rd_address: got %h, want 10", obs_addr); end
    n_checks++; if (obs_strb !== 4'hF) begin n_fail++; $display("FAIL rd_strobe: got %h, want f", obs_strb); end
    n_checks++; if (obs_wdata !== 32'h0) begin n_fail++; $display("FAIL rd_wdata: got %h, want 0", obs_wdata); end
    n_checks++; if (obs_prdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_prdata: got %h, want deadbeef", obs_prdata); end
    n_checks++; if (obs_pslverr !== 1'b0) begin n_fail++; $display("FAIL rd_pslverr: got %b, want 0", obs_pslverr); end
    n_checks++; if (obs_cycles !== 3) begin n_fail++; $display("FAIL rd_cycles: got %0d, want 3", obs_cycles); end
    // EXOKAY is a success status: data is returned without error.
    apb_xfer(1'b0, 8'h2E, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 2'b01);
    n_checks++; if (obs_addr !== 8'h2C) begin n_fail++; $display("FAIL exok_address: got %h, want 2c", obs_addr); end
    n_checks++; if (obs_prdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL exok_prdata: got %h, want 0badf00d", obs_prdata); end
    n_checks++; if (obs_pslverr !== 1'b0) begin n_fail++; $display("FAIL exok_pslverr: got %b, want 0", obs_pslverr); end
    n_checks++; if (obs_cycles !== 4) begin n_fail++; $display("FAIL exok_cycles: got %0d, want 4", obs_cycles); end
  endtask

  task automatic test_error();
    apb_xfer(1'b0, 8'h20, 32'h0, 4'h0, 1, 32'h5555_AAAA, 2'b10);
    n_checks++; if (obs_pslverr !== 1'b1) begin n_fail++; $display("FAIL slverr_pslverr: got %b, want 1", obs_pslverr); end
    n_checks++; if (obs_prdata !== 32'h0) begin n_fail++; $display("FAIL slverr_prdata: got %h, want 0", obs_prdata); end
    apb_xfer(1'b1, 8'h34, 32'h1111_2222, 4'hC, 0, 32'h9999_9999, 2'b11);
    n_checks++; if (obs_pslverr !== 1'b1) begin n_fail++; $display("FAIL decerr_pslverr: got %b, want 1", obs_pslverr); end
    n_checks++; if (obs_prdata !== 32'h0) begin n_fail++; $display("FAIL decerr_prdata: got %h, want 0", obs_prdata); end
    n_checks++; if (obs_strb !== 4'hC) begin n_fail++; $display("FAIL decerr_strobe: got %h, want c", obs_strb); end
  endtask

  task automatic test_back_to_back();
    apb_xfer(1'b1, 8'h04, 32'hA5A5_5A5A, 4'hF, 0, 32'h0, 2'b00);
    n_checks++; if (obs_cycles !== 3) begin n_fail++; $display("FAIL b2b_first_cycles: got %0d, want 3", obs_cycles); end
    n_checks++; if (obs_valid_cycles !== 1) begin n_fail++; $display("FAIL b2b_first_valid: got %0d, want 1", obs_valid_cycles); end
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, 0, 32'h0123_4567, 2'b00);
    n_checks++; if (obs_valid_at_setup !== 1'b0) begin n_fail++; $display("FAIL b2b_overlap: valid=%b at second setup, want 0", obs_valid_at_setup); end
    n_checks++; if (obs_cycles !== 3) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d, want 3", obs_cycles); end
    n_checks++; if (obs_valid_cycles !== 1) begin n_fail++; $display("FAIL b2b_second_valid: got %0d, want 1", obs_valid_cycles); end
    n_checks++; if (obs_prdata !== 32'h0123_4567) begin n_fail++; $display("FAIL b2b_prdata: got %h, want 01234567", obs_prdata); end
  endtask

  task automatic test_psel_drop();
    i_psel = 1; i_penable = 0; i_pwrite = 0; i_paddr = 8'h30;
    step();
    n_checks++; if (o_register_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid_busy: got %b, want 1", o_register_valid); end
    i_psel = 0; i_penable = 0;
    step();
    n_checks++; if (o_register_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid_held: got %b, want 1", o_register_valid); end
    i_register_ready = 1; i_register_read_data = 32'hFFFF_0000;
    step();
    i_register_ready = 0; i_register_read_data = '0;
    n_checks++; if (o_pready !== 1'b0) begin n_fail++; $display("FAIL drop_pready: got %b, want 0", o_pready); end
    n_checks++; if (o_register_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid_done: got %b, want 0", o_register_valid); end
    step();
    n_checks++; if (o_pready !== 1'b0) begin n_fail++; $display("FAIL drop_pready_late: got %b, want 0", o_pready); end
  endtask

  task automatic test_reset_busy();
    i_psel = 1; i_penable = 0; i_pwrite = 1; i_paddr = 8'h18; i_pwdata = 32'h7; i_pstrb = 4'h1;
    step();
    n_checks++; if (o_register_valid !== 1'b1) begin n_fail++; $display("FAIL rstb_valid_busy: got %b, want 1", o_register_valid); end
    i_rst = 1; idle_inputs();
    step();
    n_checks++; if (o_register_valid !== 1'b0) begin n_fail++; $display("FAIL rstb_valid: got %b, want 0", o_register_valid); end
    n_checks++; if (o_pready !== 1'b0) begin n_fail++; $display("FAIL rstb_pready: got %b, want 0", o_pready); end
    i_rst = 0;
    step();
    // A stray ready while idle must not produce a response.
    i_register_ready = 1;
    step();
    i_register_ready = 0;
    n_checks++; if (o_pready !== 1'b0) begin n_fail++; $display("FAIL stray_ready_pready: got %b, want 0", o_pready); end
    apb_xfer(1'b0, 8'h1C, 32'h0, 4'h0, 1, 32'hCAFE_F00D, 2'b00);
    n_checks++; if (obs_prdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rstb_after_prdata: got %h, want cafef00d", obs_prdata); end
    n_checks++; if (obs_cycles !== 4) begin n_fail++; $display("FAIL rstb_after_cycles: got %0d, want 4", obs_cycles); end
    n_checks++; if (obs_addr !== 8'h1C) begin n_fail++; $display("FAIL rstb_after_address: got %h, want 1c", obs_addr); end
  endtask

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    apb_xfer(1'b0, 8'h24, 32'h0, 4'h0, 1000, 32'hFFFF_FFFF, 2'b00);
    n_checks++; if (obs_valid_cycles !== 4) begin n_fail++; $display("FAIL to_valid_cycles: got %0d, want 4", obs_valid_cycles); end
    n_checks++; if (obs_cycles !== 6) begin n_fail++; $display("FAIL to_cycles: got %0d, want 6", obs_cycles); end
    n_checks++; if (obs_pslverr !== 1'b1) begin n_fail++; $display("FAIL to_pslverr: got %b, want 1", obs_pslverr); end
    n_checks++; if (obs_prdata !== 32'h0) begin n_fail++; $display("FAIL to_prdata: got %h, want 0", obs_prdata); end
  endtask
`else
  task automatic test_timeout();
    // Without the timeout feature a slow register answer well past TIMEOUT_CYCLES still succeeds.
    apb_xfer(1'b0, 8'h24, 32'h0, 4'h0, 20, 32'h7777_7777, 2'b00);
    n_checks++; if (obs_valid_cycles !== 21) begin n_fail++; $display("FAIL nto_valid_cycles: got %0d, want 21", obs_valid_cycles); end
    n_checks++; if (obs_cycles !== 23) begin n_fail++; $display("FAIL nto_cycles: got %0d, want 23", obs_cycles); end
    n_checks++; if (obs_pslverr !== 1'b0) begin n_fail++; $display("FAIL nto_pslverr: got %b, want 0", obs_pslverr); end
    n_checks++; if (obs_prdata !== 32'h7777_7777) begin n_fail++; $display("FAIL nto_prdata: got %h, want 77777777", obs_prdata); end
  endtask
`endif

  initial begin
    i_rst = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_error();
    test_back_to_back();
    test_psel_drop();
    test_reset_busy();
    test_timeout();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
